// File: rtl/uart_rx_fifo.sv
// Receive buffer behind uart_receiver: captures each character plus its error flags on
// the rising edge of rx_done and presents the oldest entry in show-ahead form.
module uart_rx_fifo #(
  parameter int DATA_SIZE = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_SIZE = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx_done,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 parity_error_in,
  input  logic                 stop_error_in,
  input  logic                 break_error_in,
  input  logic                 rd_en,
  input  logic                 overflow_clr,
  input  logic [ADDR_SIZE:0]   rx_threshold,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 rd_parity_error,
  output logic                 rd_stop_error,
  output logic                 rd_break_error,
  output logic                 empty,
  output logic                 full,
  output logic [ADDR_SIZE:0]   count,
  output logic                 threshold_hit,
  output logic                 overflow
);

  localparam int                 ENTRY_W   = DATA_SIZE + 3;
  localparam logic [ADDR_SIZE:0] DEPTH_CNT = (ADDR_SIZE + 1)'(DEPTH);
  localparam logic [ADDR_SIZE:0] CNT_ONE   = (ADDR_SIZE + 1)'(1);
  localparam logic [ADDR_SIZE-1:0] PTR_ONE = ADDR_SIZE'(1);

  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic                 rx_done_d;
  logic                 wr_req;
  logic                 rd_req;
  logic                 wr_acc;
  logic                 wr_drop;
  logic [ENTRY_W-1:0]   head;
  logic [ADDR_SIZE:0]   thr_eff;

  // Handshake: a write is requested once per rising edge of rx_done (no backpressure,
  // a write into a full buffer is dropped unless a pop happens at the same edge);
  // rd_en pops the head at the clock edge only when empty is low, otherwise it is ignored.
  assign wr_req  = rx_done & ~rx_done_d;
  assign rd_req  = rd_en & ~empty;
  assign wr_acc  = wr_req & (~full | rd_req);
  assign wr_drop = wr_req & full & ~rd_req;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign thr_eff = (rx_threshold == '0) ? CNT_ONE : rx_threshold;
  assign threshold_hit = (count >= thr_eff);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      rx_done_d <= 1'b0;
    end else begin
      rx_done_d <= rx_done;
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_req) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_acc, rd_req})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (wr_drop)           overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  // When full with a simultaneous pop, wr_ptr equals rd_ptr: the head is consumed
  // at the same edge that overwrites its slot.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= {break_error_in, stop_error_in, parity_error_in, data_in};
  end

  assign head            = mem[rd_ptr];
  assign rd_data         = empty ? '0 : head[DATA_SIZE-1:0];
  assign rd_parity_error = empty ? 1'b0 : head[DATA_SIZE];
  assign rd_stop_error   = empty ? 1'b0 : head[DATA_SIZE+1];
  assign rd_break_error  = empty ? 1'b0 : head[DATA_SIZE+2];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a queue model of the buffer predicts head entry,
// occupancy and flags after every step.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx_done;
  logic [7:0] data_in;
  logic       parity_error_in;
  logic       stop_error_in;
  logic       break_error_in;
  logic       rd_en;
  logic       overflow_clr;
  logic [4:0] rx_threshold;
  logic [7:0] rd_data;
  logic       rd_parity_error;
  logic       rd_stop_error;
  logic       rd_break_error;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       threshold_hit;
  logic       overflow;

  logic [10:0] exp_q[$];
  logic        m_ovf;
  int          assert_cnt = 0;
  int          fail_cnt   = 0;

  uart_rx_fifo dut (
    .clk(clk), .reset_n(reset_n), .rx_done(rx_done), .data_in(data_in),
    .parity_error_in(parity_error_in), .stop_error_in(stop_error_in),
    .break_error_in(break_error_in), .rd_en(rd_en), .overflow_clr(overflow_clr),
    .rx_threshold(rx_threshold), .rd_data(rd_data), .rd_parity_error(rd_parity_error),
    .rd_stop_error(rd_stop_error), .rd_break_error(rd_break_error), .empty(empty),
    .full(full), .count(count), .threshold_hit(threshold_hit), .overflow(overflow)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] dut_head();
    return {rd_break_error, rd_stop_error, rd_parity_error, rd_data};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    int thr;
    thr = (rx_threshold == 5'd0) ? 1 : int'(rx_threshold);
    check("count", 32'(count), 32'(exp_q.size()));
    check("empty", 32'(empty), 32'(exp_q.size() == 0));
    check("full", 32'(full), 32'(exp_q.size() == DEPTH));
    check("threshold_hit", 32'(threshold_hit), 32'(exp_q.size() >= thr));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("head", 32'(dut_head()), (exp_q.size() == 0) ? 32'h0 : 32'(exp_q[0]));
  endtask

  // One step: a rising edge of rx_done (if wr), rd_en, overflow_clr for one cycle,
  // then an idle cycle so the next write sees a fresh rising edge.
  task automatic drive_cycle(input logic wr, input logic rd, input logic clr,
                             input logic [10:0] ent);
    int sz;
    logic rd_req;
    logic dropped;
    sz      = exp_q.size();
    rd_req  = rd && (sz > 0);
    dropped = wr && (sz == DEPTH) && !rd_req;
    if (rd_req) check("pop_data", 32'(dut_head()), 32'(exp_q[0]));
    rx_done = wr;
    rd_en = rd;
    overflow_clr = clr;
    {break_error_in, stop_error_in, parity_error_in, data_in} = ent;
    if (rd_req) void'(exp_q.pop_front());
    if (wr && !dropped) exp_q.push_back(ent);
    if (dropped) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(negedge clk);
    rx_done = 1'b0;
    rd_en = 1'b0;
    overflow_clr = 1'b0;
    @(negedge clk);
    check_state();
  endtask

  task automatic write_char(input logic [10:0] ent);
    drive_cycle(1'b1, 1'b0, 1'b0, ent);
  endtask

  task automatic pop_char();
    drive_cycle(1'b0, 1'b1, 1'b0, 11'h0);
  endtask

  task automatic drain();
    while (exp_q.size() > 0) pop_char();
  endtask

  initial begin
    // reset
    reset_n = 1'b0;
    rx_done = 1'b0; rd_en = 1'b0; overflow_clr = 1'b0;
    data_in = '0; parity_error_in = 1'b0; stop_error_in = 1'b0; break_error_in = 1'b0;
    rx_threshold = 5'd8;
    m_ovf = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_state();

    // single write with parity flag, visible one cycle after the write edge
    rx_done = 1'b1; data_in = 8'hA5; parity_error_in = 1'b1;
    exp_q.push_back({3'b001, 8'hA5});
    @(negedge clk);
    check("latency_empty", 32'(empty), 32'h0);
    check("latency_data", 32'(rd_data), 32'hA5);
    check("latency_parity", 32'(rd_parity_error), 32'h1);
    rx_done = 1'b0; parity_error_in = 1'b0;
    @(negedge clk);
    check_state();
    pop_char();

    // held rx_done writes once
    rx_done = 1'b1; data_in = 8'h3C;
    exp_q.push_back({3'b000, 8'h3C});
    repeat (5) @(negedge clk);
    rx_done = 1'b0;
    @(negedge clk);
    check_state();
    pop_char();

    // flags round-trip
    write_char({3'b110, 8'h81});
    write_char({3'b011, 8'h42});
    drain();

    // asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) write_char({3'b000, 8'(8'h60 + i)});
    #2 reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("async_rst_count", 32'(count), 32'h0);
    check("async_rst_empty", 32'(empty), 32'h1);
    check("async_rst_data", 32'(rd_data), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_state();

    // fill, partial drain, wrap, full drain
    for (int i = 0; i < 16; i++) write_char({3'b000, 8'(i)});
    check("fill_full", 32'(full), 32'h1);
    for (int i = 0; i < 4; i++) pop_char();
    check("wrap_head", 32'(rd_data), 32'h04);
    for (int i = 0; i < 4; i++) write_char({3'b000, 8'(8'h10 + i)});
    check("wrap_full", 32'(full), 32'h1);
    drain();

    // overflow
    for (int i = 0; i < 16; i++) write_char({3'b000, 8'(8'h20 + i)});
    write_char({3'b000, 8'hFF});
    check("ovf_set", 32'(overflow), 32'h1);
    drive_cycle(1'b1, 1'b1, 1'b0, {3'b100, 8'h77});
    drive_cycle(1'b1, 1'b0, 1'b1, {3'b000, 8'hEE});
    check("ovf_set_wins", 32'(overflow), 32'h1);
    drive_cycle(1'b0, 1'b0, 1'b1, 11'h0);
    check("ovf_cleared", 32'(overflow), 32'h0);
    drain();

    // threshold and read-on-empty with write
    rx_threshold = 5'd4;
    @(negedge clk);
    check_state();
    for (int i = 1; i <= 4; i++) write_char({3'b000, 8'(i)});
    check("thr_hit_at_4", 32'(threshold_hit), 32'h1);
    drain();
    drive_cycle(1'b1, 1'b1, 1'b0, {3'b000, 8'h5A});
    check("empty_rd_count", 32'(count), 32'h1);
    check("empty_rd_data", 32'(rd_data), 32'h5A);
    rx_threshold = 5'd0;
    @(negedge clk);
    check_state();
    rx_threshold = 5'd16;
    @(negedge clk);
    check_state();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of uart_receiver. It captures each received character together with its parity, stop and break error flags on the rising edge of rx_done. It holds the entries in a circular buffer and presents them to the host/register interface in show-ahead (first-word-fall-through) form. It also reports full, empty, occupancy, a programmable level threshold and a sticky overflow flag.

Parameters:
DATA_SIZE, 8, width of one received character; must match uart_receiver DATA_SIZE.
DEPTH, 16, number of entries; power of two, minimum 2.
ADDR_SIZE, $clog2(DEPTH), pointer width.

Ports:
clk  input  1  system clock; same clock as uart_receiver.
reset_n  input  1  asynchronous, active-low reset.
rx_done  input  1  receiver character-complete indication; a write occurs on its rising edge.
data_in  input  DATA_SIZE  received character (uart_receiver data_out).
parity_error_in  input  1  parity error for this character.
stop_error_in  input  1  stop (framing) error for this character.
break_error_in  input  1  break condition for this character.
rd_en  input  1  pop head entry at this clock edge.
overflow_clr  input  1  clear sticky overflow.
rx_threshold  input  ADDR_SIZE+1  level threshold, 1..DEPTH.
rd_data  output  DATA_SIZE  head-entry character.
rd_parity_error  output  1  head-entry parity flag.
rd_stop_error  output  1  head-entry stop flag.
rd_break_error  output  1  head-entry break flag.
empty  output  1  no entries.
full  output  1  DEPTH entries.
count  output  ADDR_SIZE+1  occupancy, 0..DEPTH.
threshold_hit  output  1  count >= rx_threshold.
overflow  output  1  sticky: a write was dropped because the buffer was full.

Behaviour:
- Storage: DEPTH x (DATA_SIZE+3) array of {break, stop, parity, data}. The write pointer (wr_ptr), read pointer (rd_ptr) and count are registered. Pointers wrap modulo DEPTH (natural ADDR_SIZE overflow).
- Reset (asynchronous, any time, including mid-operation): wr_ptr=0, rd_ptr=0, count=0, overflow=0, rx_done_d=0. Outputs become empty=1, full=0, threshold_hit=0, rd_data=0, all rd_*_error=0. Array contents are not reset and are treated as invalid.
- Write detect: a registered copy rx_done_d is kept. wr_req = rx_done & ~rx_done_d, so a level held high for several cycles writes exactly once. Data and flags are sampled in the wr_req cycle.
- Read: rd_req = rd_en & ~empty. rd_en while empty is ignored; no state changes.
- Per clock edge:
  - wr_req & ~full: store at wr_ptr, wr_ptr+1.
  - wr_req & full & ~rd_req: write dropped, overflow<=1, contents unchanged.
  - wr_req & full & rd_req: pop and push both happen, count stays DEPTH, no overflow.
  - wr_req & empty & rd_en: read ignored, write accepted, count 0->1.
  - rd_req: rd_ptr+1.
  - count += wr_accepted - rd_req.
- Show-ahead: when empty=0, rd_data and rd_*_error combinationally reflect the entry at rd_ptr. When empty=1 they are forced to 0. A written character appears on rd_data the cycle after the wr_req edge.
- Derived flags: empty = (count==0); full = (count==DEPTH); threshold_hit = (count >= rx_threshold). rx_threshold=0 is treated as 1.
- Overflow flag: set on a dropped write; cleared by overflow_clr. If set and clear occur in the same cycle, set wins.
- Latency: write-to-visible is 1 cycle. rd_en pop takes effect at the same edge, and the next head is visible immediately after it.

Test Plan:
- Reset then idle: empty=1, full=0, count=0, overflow=0, rd_data=0x00. Assert reset_n=0 after 3 writes -> count=0, empty=1 asynchronously, before the next clk edge.
- Single write: rx_done pulse with data_in=0xA5, parity_error_in=1 -> next cycle empty=0, count=1, rd_data=0xA5, rd_parity_error=1. rd_en for 1 cycle -> empty=1, rd_data=0x00.
- rx_done held high for 5 cycles with data_in=0x3C -> count=1 only.
- Fill and wrap: write 0x00..0x0F (DEPTH=16) -> full=1, count=16. Pop 4 -> rd_data=0x04. Write 0x10..0x13 -> full=1. Drain all 16 -> order 0x04..0x13, empty=1.
- Overflow: full buffer, write 0xFF without rd_en -> overflow=1, count=16, head unchanged. Write with rd_en the same cycle -> no drop, count=16. Assert overflow_clr together with another dropped write -> overflow stays 1. Assert overflow_clr alone -> overflow=0.
- Threshold/empty read: rx_threshold=4; writes 1..3 -> threshold_hit=0, 4th write -> 1. rd_en on empty buffer together with a write of 0x5A -> count=1, rd_data=0x5A.
